// File: rtl/pcnn_pkg.sv
// rtl/pcnn_pkg.sv - shared types, default widths and phase-length helpers for the pcnn feeder
package pcnn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GO,
        ST_IMG,
        ST_KER,
        ST_WAIT,
        ST_FIN
    } state_t;

    localparam int DW_DEF = 8;
    localparam int WW_DEF = 9;
    localparam int OW_DEF = 20;

    function automatic int img_len(input int as);
        return as * as;
    endfunction

    function automatic int ker_len(input int bs);
        return bs * bs;
    endfunction

endpackage

// File: rtl/pcnn_addr_gen.sv
// rtl/pcnn_addr_gen.sv - phase counter and one-ahead prefetch address generator
module pcnn_addr_gen
    import pcnn_pkg::*;
#(
    parameter int AS    = 6,
    parameter int BS    = 3,
    parameter int AW    = 8,
    parameter int KBASE = 36
) (
    input  logic          clk,
    input  logic          reset,
    input  state_t        phase_i,
    input  logic          step_i,
    output logic [AW-1:0] mem_addr_o,
    output logic          mem_rd_o,
    output logic          img_last_o,
    output logic          ker_last_o
);

    localparam int IMG_N = img_len(AS);
    localparam int KER_N = ker_len(BS);
    localparam int CW    = $clog2((IMG_N > KER_N) ? IMG_N : KER_N) + 1;

    localparam logic [AW-1:0] IMG_END   = AW'(IMG_N - 1);
    localparam logic [AW-1:0] KER_START = AW'(KBASE);
    localparam logic [AW-1:0] KER_END   = AW'(KBASE + KER_N - 1);
    localparam logic [CW-1:0] IMG_CLAST = CW'(IMG_N - 1);
    localparam logic [CW-1:0] KER_CLAST = CW'(KER_N - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          rd_q, rd_d;

    assign img_last_o = (phase_i == ST_IMG) && (cnt_q == IMG_CLAST);
    assign ker_last_o = (phase_i == ST_KER) && (cnt_q == KER_CLAST);
    assign mem_addr_o = addr_q;
    assign mem_rd_o   = rd_q;

    always_comb begin
        cnt_d = cnt_q;
        if (img_last_o || ker_last_o || !(phase_i == ST_IMG || phase_i == ST_KER)) begin
            cnt_d = '0;
        end else if (step_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // The address leads the FSM by one cycle so data lands as the phase consumes it.
    always_comb begin
        addr_d = addr_q;
        rd_d   = rd_q;
        if (step_i) begin
            if (phase_i == ST_IDLE) begin
                addr_d = '0;
                rd_d   = 1'b1;
            end else if (rd_q) begin
                if (addr_q == IMG_END) begin
                    addr_d = KER_START;
                end else if (addr_q == KER_END) begin
                    rd_d = 1'b0;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            addr_q <= '0;
            rd_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
            rd_q   <= rd_d;
        end
    end

endmodule

// File: rtl/pcnn_feeder.sv
// rtl/pcnn_feeder.sv - loads image and kernel from memory into pcnn, waits for done, reports result
module pcnn_feeder
    import pcnn_pkg::*;
#(
    parameter int AS    = 6,
    parameter int BS    = 3,
    parameter int AW    = 8,
    parameter int KBASE = 36,
    parameter int DW    = DW_DEF,
    parameter int WW    = WW_DEF,
    parameter int OW    = OW_DEF,
    parameter int TMO   = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [WW-1:0] mem_rdata,
    output logic          go_o,
    output logic [DW-1:0] a_o,
    output logic [WW-1:0] b_o,
    input  logic          done_i,
    input  logic [OW-1:0] out_i,
    output logic [OW-1:0] result,
    output logic          finish,
    output logic          timeout
);

    if (!((img_len(AS) <= KBASE) && (KBASE + ker_len(BS) <= (1 << AW)) && (DW <= WW)))
    begin : g_param_check
        $error("pcnn_feeder: image/kernel layout does not fit the memory map");
    end

    localparam int TW = $clog2(TMO + 1);

    state_t        state_q, state_d;
    logic [TW-1:0] wcnt_q, wcnt_d;
    logic          busy_q, busy_d;
    logic          go_q, go_d;
    logic [DW-1:0] a_q, a_d;
    logic [WW-1:0] b_q, b_d;
    logic [OW-1:0] cap_q, cap_d;
    logic [OW-1:0] res_q, res_d;
    logic          fin_q, fin_d;
    logic          tmo_q, tmo_d;

    logic accept, step, img_last, ker_last, tmo_hit;

    // busy_q lingers one cycle in IDLE after FIN; a start there is not taken.
    assign accept  = (state_q == ST_IDLE) && start && !busy_q;
    assign step    = accept || (state_q == ST_GO) || (state_q == ST_IMG) || (state_q == ST_KER);
    assign tmo_hit = (wcnt_q == TW'(TMO - 1));

    pcnn_addr_gen #(
        .AS    (AS),
        .BS    (BS),
        .AW    (AW),
        .KBASE (KBASE)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .phase_i    (state_q),
        .step_i     (step),
        .mem_addr_o (mem_addr),
        .mem_rd_o   (mem_rd),
        .img_last_o (img_last),
        .ker_last_o (ker_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept)   state_d = ST_GO;
            ST_GO:                 state_d = ST_IMG;
            ST_IMG:  if (img_last) state_d = ST_KER;
            ST_KER:  if (ker_last) state_d = ST_WAIT;
            ST_WAIT: begin
                if (done_i)       state_d = ST_FIN;
                else if (tmo_hit) state_d = ST_IDLE;
            end
            ST_FIN:                state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_d = busy_q;
        go_d   = go_q;
        a_d    = a_q;
        b_d    = b_q;
        cap_d  = cap_q;
        res_d  = res_q;
        fin_d  = 1'b0;
        tmo_d  = tmo_q;
        wcnt_d = (state_q == ST_WAIT) ? wcnt_q + TW'(1) : '0;
        unique case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (accept) begin
                    busy_d = 1'b1;
                    go_d   = 1'b1;
                    a_d    = '0;
                    b_d    = '0;
                    tmo_d  = 1'b0;
                end
            end
            ST_IMG:  a_d = mem_rdata[DW-1:0];
            ST_KER:  b_d = mem_rdata;
            ST_WAIT: begin
                if (done_i) begin
                    cap_d = out_i;
                end else if (tmo_hit) begin
                    tmo_d  = 1'b1;
                    go_d   = 1'b0;
                    busy_d = 1'b0;
                end
            end
            ST_FIN: begin
                res_d = cap_q;
                fin_d = 1'b1;
                go_d  = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt_q <= '0;
            busy_q <= 1'b0;
            go_q   <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            cap_q  <= '0;
            res_q  <= '0;
            fin_q  <= 1'b0;
            tmo_q  <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            busy_q <= busy_d;
            go_q   <= go_d;
            a_q    <= a_d;
            b_q    <= b_d;
            cap_q  <= cap_d;
            res_q  <= res_d;
            fin_q  <= fin_d;
            tmo_q  <= tmo_d;
        end
    end

    assign busy    = busy_q;
    assign go_o    = go_q;
    assign a_o     = a_q;
    assign b_o     = b_q;
    assign result  = res_q;
    assign finish  = fin_q;
    assign timeout = tmo_q;

endmodule
